// File: rtl/umi_isolate_ctrl_pkg.sv
// Shared types and constants for the UMI power-domain quiesce controller.
package umi_isolate_ctrl_pkg;

  // Controller states; encoding is fixed so checkers can decode the state bus.
  typedef enum logic [1:0] {
    ST_ACTIVE   = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_ISOLATED = 2'd2,
    ST_WAKE     = 2'd3
  } state_t;

  // UMI request opcodes (cmd[4:0]).
  localparam logic [4:0] UMI_REQ_READ   = 5'h01;
  localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
  localparam logic [4:0] UMI_REQ_POSTED = 5'h05;
  localparam logic [4:0] UMI_REQ_RDMA   = 5'h07;
  localparam logic [4:0] UMI_REQ_ATOMIC = 5'h09;

  // UMI response opcode used for read data returns.
  localparam logic [4:0] UMI_RESP_READ  = 5'h02;

  // End-of-message flag position inside cmd.
  localparam int EOM_BIT = 22;

  // True for request opcodes that will produce a response from the far side.
  function automatic logic needs_resp(input logic [4:0] opcode);
    return (opcode == UMI_REQ_READ)  || (opcode == UMI_REQ_WRITE) ||
           (opcode == UMI_REQ_RDMA)  || (opcode == UMI_REQ_ATOMIC);
  endfunction

endpackage

// File: rtl/umi_isolate_ctrl_cnt.sv
// Saturating up/down counter of responses still owed by the switchable domain.
module umi_isolate_ctrl_cnt #(
  parameter int OW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [OW-1:0] count,
  output logic          full,
  output logic          underflow
);

  localparam logic [OW-1:0] CNT_MAX = '1;

  assign full = (count == CNT_MAX);
  // A lone decrement at zero means a response arrived that nobody asked for.
  assign underflow = dec & ~inc & (count == '0);

  // Count holds on simultaneous inc/dec, saturates at both ends.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + OW'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - OW'(1);
    end
  end

endmodule

// File: rtl/umi_isolate_ctrl.sv
// Quiesce controller in front of umi_isolate: closes the request channel at a
// packet boundary, waits for outstanding responses, then asserts isolate.
//
// Handshake: a transfer happens on a cycle where valid & ready are both high.
// Valid is never withdrawn once raised by the upstream; this block only masks
// valid/ready together through 'open', which changes only at packet boundaries.
module umi_isolate_ctrl
  import umi_isolate_ctrl_pkg::*;
#(
  parameter int CW            = 32,
  parameter int AW            = 64,
  parameter int DW            = 256,
  parameter int OW            = 8,
  parameter int WAKE_CYCLES   = 16,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          iso_req,
  output logic          isolate,
  output logic          iso_ack,
  output logic          drain_err,
  output logic [OW-1:0] outstanding,
  output state_t        state,
  // host-side request
  input  logic          req_in_valid,
  input  logic [CW-1:0] req_in_cmd,
  input  logic [AW-1:0] req_in_dstaddr,
  input  logic [AW-1:0] req_in_srcaddr,
  input  logic [DW-1:0] req_in_data,
  output logic          req_in_ready,
  // request toward umi_isolate
  output logic          req_out_valid,
  output logic [CW-1:0] req_out_cmd,
  output logic [AW-1:0] req_out_dstaddr,
  output logic [AW-1:0] req_out_srcaddr,
  output logic [DW-1:0] req_out_data,
  input  logic          req_out_ready,
  // response from umi_isolate
  input  logic          resp_in_valid,
  input  logic [CW-1:0] resp_in_cmd,
  input  logic [AW-1:0] resp_in_dstaddr,
  input  logic [AW-1:0] resp_in_srcaddr,
  input  logic [DW-1:0] resp_in_data,
  output logic          resp_in_ready,
  // response toward host
  output logic          resp_out_valid,
  output logic [CW-1:0] resp_out_cmd,
  output logic [AW-1:0] resp_out_dstaddr,
  output logic [AW-1:0] resp_out_srcaddr,
  output logic [DW-1:0] resp_out_data,
  input  logic          resp_out_ready
);

  localparam int TW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam int WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

  state_t          state_next;
  logic            mid_pkt;
  logic [TW-1:0]   drain_timer;
  logic [WW-1:0]   wake_timer;
  logic            drain_done;
  logic            wake_done;
  logic            timeout;
  logic            open;
  logic            sat_block;
  logic            req_fire;
  logic            req_eom;
  logic            req_nr;
  logic            cnt_inc;
  logic            cnt_dec;
  logic            cnt_full;
  logic            cnt_underflow;

  // Datapath fields pass straight through; only valid/ready are gated.
  assign req_out_cmd      = req_in_cmd;
  assign req_out_dstaddr  = req_in_dstaddr;
  assign req_out_srcaddr  = req_in_srcaddr;
  assign req_out_data     = req_in_data;
  assign resp_out_valid   = resp_in_valid;
  assign resp_out_cmd     = resp_in_cmd;
  assign resp_out_dstaddr = resp_in_dstaddr;
  assign resp_out_srcaddr = resp_in_srcaddr;
  assign resp_out_data    = resp_in_data;
  assign resp_in_ready    = resp_out_ready;

  assign req_eom = req_in_cmd[EOM_BIT];
  assign req_nr  = needs_resp(req_in_cmd[4:0]);

  // A full counter stalls new response-expecting messages, but never the
  // continuation of a message already in progress.
  assign sat_block = cnt_full & req_nr & ~mid_pkt;
  assign open      = ((state == ST_ACTIVE) | mid_pkt) & ~sat_block;

  assign req_out_valid = req_in_valid & open;
  assign req_in_ready  = req_out_ready & open;
  assign req_fire      = req_in_valid & req_in_ready;

  assign cnt_inc = req_fire & req_eom & req_nr;
  assign cnt_dec = resp_in_valid & resp_out_ready & resp_in_cmd[EOM_BIT];

  assign drain_done = (DRAIN_TIMEOUT != 0) && (drain_timer == TW'(DRAIN_TIMEOUT - 1));
  assign wake_done  = (wake_timer == WW'(WAKE_CYCLES - 1));

  assign iso_ack = isolate;

  umi_isolate_ctrl_cnt #(.OW(OW)) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .clr       (timeout),
    .inc       (cnt_inc),
    .dec       (cnt_dec),
    .count     (outstanding),
    .full      (cnt_full),
    .underflow (cnt_underflow)
  );

  // Next-state decode; drain completion wins over timeout on the same cycle.
  always_comb begin
    state_next = state;
    timeout    = 1'b0;
    case (state)
      ST_ACTIVE: begin
        if (iso_req) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!iso_req) begin
          state_next = ST_ACTIVE;
        end else if ((outstanding == '0) && !mid_pkt) begin
          state_next = ST_ISOLATED;
        end else if (drain_done) begin
          state_next = ST_ISOLATED;
          timeout    = 1'b1;
        end
      end
      ST_ISOLATED: begin
        if (!iso_req) state_next = ST_WAKE;
      end
      ST_WAKE: begin
        if (iso_req) begin
          state_next = ST_ISOLATED;
        end else if (wake_done) begin
          state_next = ST_ACTIVE;
        end
      end
      default: state_next = ST_ACTIVE;
    endcase
  end

  // State, isolate flop, timers, packet tracking and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_ACTIVE;
      isolate     <= 1'b0;
      drain_err   <= 1'b0;
      mid_pkt     <= 1'b0;
      drain_timer <= '0;
      wake_timer  <= '0;
    end else begin
      state     <= state_next;
      isolate   <= (state_next == ST_ISOLATED);
      drain_err <= drain_err | timeout | cnt_underflow;
      if (req_fire) mid_pkt <= ~req_eom;
      drain_timer <= ((state == ST_DRAIN) && (state_next == ST_DRAIN)) ?
                     drain_timer + TW'(1) : '0;
      wake_timer  <= ((state == ST_WAKE) && (state_next == ST_WAKE)) ?
                     wake_timer + WW'(1) : '0;
    end
  end

endmodule

// File: tb/tb_umi_isolate_ctrl.sv
// Directed bench for umi_isolate_ctrl: vector table plus multi-cycle sequences.
module tb_umi_isolate_ctrl;
  import umi_isolate_ctrl_pkg::*;

  localparam int CW = 32;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int OW = 3;
  localparam int WAKE_CYCLES = 16;
  localparam int DRAIN_TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          iso_req;
  logic          isolate;
  logic          iso_ack;
  logic          drain_err;
  logic [OW-1:0] outstanding;
  state_t        state;
  logic          req_in_valid;
  logic [CW-1:0] req_in_cmd;
  logic [AW-1:0] req_in_dstaddr;
  logic [AW-1:0] req_in_srcaddr;
  logic [DW-1:0] req_in_data;
  logic          req_in_ready;
  logic          req_out_valid;
  logic [CW-1:0] req_out_cmd;
  logic [AW-1:0] req_out_dstaddr;
  logic [AW-1:0] req_out_srcaddr;
  logic [DW-1:0] req_out_data;
  logic          req_out_ready;
  logic          resp_in_valid;
  logic [CW-1:0] resp_in_cmd;
  logic [AW-1:0] resp_in_dstaddr;
  logic [AW-1:0] resp_in_srcaddr;
  logic [DW-1:0] resp_in_data;
  logic          resp_in_ready;
  logic          resp_out_valid;
  logic [CW-1:0] resp_out_cmd;
  logic [AW-1:0] resp_out_dstaddr;
  logic [AW-1:0] resp_out_srcaddr;
  logic [DW-1:0] resp_out_data;
  logic          resp_out_ready;

  int n_cmp = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];

  umi_isolate_ctrl #(
    .CW(CW), .AW(AW), .DW(DW), .OW(OW),
    .WAKE_CYCLES(WAKE_CYCLES), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .iso_req(iso_req), .isolate(isolate),
    .iso_ack(iso_ack), .drain_err(drain_err), .outstanding(outstanding),
    .state(state),
    .req_in_valid(req_in_valid), .req_in_cmd(req_in_cmd),
    .req_in_dstaddr(req_in_dstaddr), .req_in_srcaddr(req_in_srcaddr),
    .req_in_data(req_in_data), .req_in_ready(req_in_ready),
    .req_out_valid(req_out_valid), .req_out_cmd(req_out_cmd),
    .req_out_dstaddr(req_out_dstaddr), .req_out_srcaddr(req_out_srcaddr),
    .req_out_data(req_out_data), .req_out_ready(req_out_ready),
    .resp_in_valid(resp_in_valid), .resp_in_cmd(resp_in_cmd),
    .resp_in_dstaddr(resp_in_dstaddr), .resp_in_srcaddr(resp_in_srcaddr),
    .resp_in_data(resp_in_data), .resp_in_ready(resp_in_ready),
    .resp_out_valid(resp_out_valid), .resp_out_cmd(resp_out_cmd),
    .resp_out_dstaddr(resp_out_dstaddr), .resp_out_srcaddr(resp_out_srcaddr),
    .resp_out_data(resp_out_data), .resp_out_ready(resp_out_ready)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Vector record: in_f = {iso, rv, eom, ror, sv, seom, sor}
  //                ex_f = {rov, rir, sir, isolate, iso_ack, drain_err}
  typedef struct packed {
    logic [6:0]    in_f;
    logic [4:0]    op;
    logic [5:0]    ex_f;
    logic [OW-1:0] e_out;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [CW-1:0] mk_cmd(input logic [4:0] op, input logic eom);
    logic [CW-1:0] c;
    c = '0;
    c[4:0] = op;
    c[EOM_BIT] = eom;
    return c;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic set_req(input logic v, input logic [4:0] op, input logic eom);
    req_in_valid   = v;
    req_in_cmd     = mk_cmd(op, eom);
    req_in_dstaddr = {$urandom, $urandom};
    req_in_srcaddr = {$urandom, $urandom};
    req_in_data    = {$urandom, $urandom};
  endtask

  task automatic set_resp(input logic v, input logic eom);
    resp_in_valid   = v;
    resp_in_cmd     = mk_cmd(UMI_RESP_READ, eom);
    resp_in_dstaddr = {$urandom, $urandom};
    resp_in_srcaddr = {$urandom, $urandom};
    resp_in_data    = {$urandom, $urandom};
  endtask

  // Synchronous reset; returns just after a falling edge with reset low.
  task automatic do_reset();
    reset = 1'b1;
    iso_req = 1'b0;
    req_out_ready = 1'b1;
    resp_out_ready = 1'b1;
    set_req(1'b0, UMI_REQ_READ, 1'b1);
    set_resp(1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One request/response cycle of a hand sequence, then advance past one edge.
  task automatic cycle_req(input logic [4:0] op, input logic eom, input string name,
                           input logic exp_rdy);
    set_req(1'b1, op, eom);
    #1;
    chk(name, {63'd0, req_in_ready}, {63'd0, exp_rdy});
    @(negedge clk);
    set_req(1'b0, op, eom);
  endtask

  initial begin
    int k;
    do_reset();

    // ---------- table: three reads, drain, isolate, release, wake ----------
    vecs.push_back('{7'b0011011, UMI_REQ_READ, 6'b011000, 3'd0}); // reset state
    vecs.push_back('{7'b0110011, UMI_REQ_READ, 6'b101000, 3'd0}); // ror=0 stall
    vecs.push_back('{7'b0111011, UMI_REQ_READ, 6'b111000, 3'd0}); // read 1
    vecs.push_back('{7'b0111011, UMI_REQ_READ, 6'b111000, 3'd1}); // read 2
    vecs.push_back('{7'b0111011, UMI_REQ_READ, 6'b111000, 3'd2}); // read 3
    vecs.push_back('{7'b1011011, UMI_REQ_READ, 6'b011000, 3'd3}); // iso_req, still ACTIVE
    vecs.push_back('{7'b1111011, UMI_REQ_READ, 6'b001000, 3'd3}); // DRAIN blocks read
    vecs.push_back('{7'b1011111, UMI_REQ_READ, 6'b001000, 3'd3}); // resp 1
    vecs.push_back('{7'b1011111, UMI_REQ_READ, 6'b001000, 3'd2}); // resp 2
    vecs.push_back('{7'b1011111, UMI_REQ_READ, 6'b001000, 3'd1}); // resp 3
    vecs.push_back('{7'b1011011, UMI_REQ_READ, 6'b001000, 3'd0}); // drained, isolate low
    vecs.push_back('{7'b1011011, UMI_REQ_READ, 6'b001110, 3'd0}); // ISOLATED
    vecs.push_back('{7'b0011011, UMI_REQ_READ, 6'b001110, 3'd0}); // release requested
    vecs.push_back('{7'b0111011, UMI_REQ_READ, 6'b001000, 3'd0}); // WAKE blocks read
    vecs.push_back('{7'b0011110, UMI_REQ_READ, 6'b000000, 3'd0}); // resp stalled downstream
    vecs.push_back('{7'b0011101, UMI_REQ_READ, 6'b001000, 3'd0}); // non-EOM resp at 0
    vecs.push_back('{7'b0011011, UMI_REQ_READ, 6'b001000, 3'd0}); // no error raised

    foreach (vecs[i]) begin
      iso_req        = vecs[i].in_f[6];
      set_req(vecs[i].in_f[5], vecs[i].op, vecs[i].in_f[4]);
      req_out_ready  = vecs[i].in_f[3];
      set_resp(vecs[i].in_f[2], vecs[i].in_f[1]);
      resp_out_ready = vecs[i].in_f[0];
      if (vecs[i].ex_f[5] && vecs[i].in_f[3]) exp_q.push_back(req_in_data);
      #1;
      chk($sformatf("v%0d_flags", i),
          {58'd0, req_out_valid, req_in_ready, resp_in_ready, isolate, iso_ack, drain_err},
          {58'd0, vecs[i].ex_f});
      chk($sformatf("v%0d_outstanding", i), 64'(outstanding), 64'(vecs[i].e_out));
      if (req_out_valid && req_out_ready) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("v%0d_unexpected_req", i), 64'd1, 64'd0);
        end else begin
          chk($sformatf("v%0d_req_data", i), req_out_data, exp_q.pop_front());
        end
      end
      @(negedge clk);
    end
    chk("req_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // ---------- idle drain, then wake length ----------
    do_reset();
    iso_req = 1'b1;
    #1;
    chk("idle_iso_pre", {63'd0, isolate}, 64'd0);
    @(negedge clk);
    #1;
    chk("idle_state_drain", 64'(state), 64'(ST_DRAIN));
    chk("idle_iso_n1", {63'd0, isolate}, 64'd0);
    @(negedge clk);
    #1;
    chk("idle_iso_n2", {62'd0, isolate, iso_ack}, 64'd3);
    iso_req = 1'b0;
    @(negedge clk);
    #1;
    chk("wake_iso_low", {62'd0, isolate, iso_ack}, 64'd0);
    k = 0;
    while (!req_in_ready && k < 40) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("wake_len", 64'(k), 64'(WAKE_CYCLES));

    // ---------- multi-packet write straddling iso_req ----------
    do_reset();
    cycle_req(UMI_REQ_WRITE, 1'b0, "mp_pkt1", 1'b1);
    iso_req = 1'b1;
    cycle_req(UMI_REQ_WRITE, 1'b0, "mp_pkt2", 1'b1);
    chk("mp_state_drain", 64'(state), 64'(ST_DRAIN));
    cycle_req(UMI_REQ_WRITE, 1'b1, "mp_pkt3", 1'b1);
    set_req(1'b1, UMI_REQ_READ, 1'b1);
    #1;
    chk("mp_gate_closed", {62'd0, req_out_valid, req_in_ready}, 64'd0);
    chk("mp_outstanding", 64'(outstanding), 64'd1);
    set_req(1'b0, UMI_REQ_READ, 1'b1);
    set_resp(1'b1, 1'b1);
    @(negedge clk);
    set_resp(1'b0, 1'b1);
    #1;
    chk("mp_iso_wait", {63'd0, isolate}, 64'd0);
    @(negedge clk);
    #1;
    chk("mp_iso_up", {63'd0, isolate}, 64'd1);

    // ---------- posted writes need no response ----------
    do_reset();
    for (int p = 0; p < 4; p++) cycle_req(UMI_REQ_POSTED, 1'b1, "posted_rdy", 1'b1);
    iso_req = 1'b1;
    #1;
    chk("posted_outstanding", 64'(outstanding), 64'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("posted_iso", {62'd0, isolate, iso_ack}, 64'd3);

    // ---------- drain timeout ----------
    do_reset();
    cycle_req(UMI_REQ_READ, 1'b1, "to_read", 1'b1);
    iso_req = 1'b1;
    @(negedge clk);
    #1;
    k = 0;
    while (!isolate && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("to_cycles", 64'(k), 64'(DRAIN_TIMEOUT));
    chk("to_err_ack", {62'd0, drain_err, iso_ack}, 64'd3);
    chk("to_outstanding", 64'(outstanding), 64'd0);

    // ---------- stray response at zero ----------
    do_reset();
    set_resp(1'b1, 1'b1);
    #1;
    chk("stray_err_pre", {63'd0, drain_err}, 64'd0);
    chk("resp_data_pass", resp_out_data, resp_in_data);
    @(negedge clk);
    set_resp(1'b0, 1'b1);
    #1;
    chk("stray_err", {63'd0, drain_err}, 64'd1);
    chk("stray_outstanding", 64'(outstanding), 64'd0);

    // ---------- reset in the middle of DRAIN ----------
    do_reset();
    cycle_req(UMI_REQ_READ, 1'b1, "rst_read", 1'b1);
    iso_req = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_in_drain", 64'(state), 64'(ST_DRAIN));
    reset = 1'b1;
    iso_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_state", 64'(state), 64'(ST_ACTIVE));
    chk("rst_outputs", {60'd0, isolate, iso_ack, drain_err, req_in_ready}, 64'd1);
    chk("rst_outstanding", 64'(outstanding), 64'd0);

    // ---------- counter saturation and simultaneous inc/dec ----------
    do_reset();
    for (int r = 0; r < 7; r++) cycle_req(UMI_REQ_READ, 1'b1, "sat_fill", 1'b1);
    set_req(1'b1, UMI_REQ_READ, 1'b1);
    #1;
    chk("sat_outstanding", 64'(outstanding), 64'd7);
    chk("sat_read_blocked", {62'd0, req_out_valid, req_in_ready}, 64'd0);
    set_req(1'b1, UMI_REQ_POSTED, 1'b1);
    #1;
    chk("sat_posted_ok", {63'd0, req_in_ready}, 64'd1);
    set_req(1'b0, UMI_REQ_READ, 1'b1);
    set_resp(1'b1, 1'b1);
    @(negedge clk);
    #1;
    chk("sat_dec", 64'(outstanding), 64'd6);
    set_req(1'b1, UMI_REQ_READ, 1'b1);
    @(negedge clk);
    set_req(1'b0, UMI_REQ_READ, 1'b1);
    set_resp(1'b0, 1'b1);
    #1;
    chk("inc_dec_same", 64'(outstanding), 64'd6);
    chk("sat_no_err", {63'd0, drain_err}, 64'd0);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/umi_isolate_ctrl.md
# umi_isolate_ctrl

Power-domain quiesce controller placed directly upstream of `umi_isolate`. It passes one UMI request channel into the switchable domain and one response channel out of it. On an isolation request it stops admitting new request packets at a packet boundary and waits for every outstanding response to return. Only then does it drive `isolate` high. On release it drops `isolate` and holds traffic off for a programmable wake-up interval before reopening.

## Interface
Parameters:
- `CW`, 32, UMI command width
- `AW`, 64, UMI address width
- `DW`, 256, UMI data width
- `OW`, 8, outstanding-response counter width
- `WAKE_CYCLES`, 16, idle cycles after `isolate` falls before traffic resumes (≥1)
- `DRAIN_TIMEOUT`, 1024, max DRAIN cycles before forced isolation (0 = never)

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `iso_req`  in  1  request isolation (level)
- `isolate`  out  1  registered; drives `umi_isolate.isolate`
- `iso_ack`  out  1  high only in ISOLATED
- `drain_err`  out  1  sticky; set on drain timeout or response underflow; cleared by reset
- `outstanding`  out  OW  current outstanding-response count
- `req_in_valid`, `req_in_cmd[CW]`, `req_in_dstaddr[AW]`, `req_in_srcaddr[AW]`, `req_in_data[DW]`  in  host-side request
- `req_in_ready`  out  1
- `req_out_valid`, `req_out_cmd`, `req_out_dstaddr`, `req_out_srcaddr`, `req_out_data`  out  toward `umi_isolate`
- `req_out_ready`  in  1
- `resp_in_valid`, `resp_in_cmd`, `resp_in_dstaddr`, `resp_in_srcaddr`, `resp_in_data`  in  from `umi_isolate`
- `resp_in_ready`  out  1
- `resp_out_*` (valid/cmd/dstaddr/srcaddr/data)  out;  `resp_out_ready`  in

## Operation
- Data and address fields pass through combinationally. Only valid/ready are gated: `req_out_valid = req_in_valid & open`, `req_in_ready = req_out_ready & open`.
- `open` is true in ACTIVE, or in any state while `mid_pkt` is set.
- A request packet needs a response when its opcode (`cmd[4:0]`) is REQ_READ, REQ_WRITE, REQ_RDMA or REQ_ATOMIC. REQ_POSTED and others are excluded.
- Counter increments on an accepted request with `cmd[22]` (EOM) = 1 that needs a response.
- Counter decrements on an accepted response (`resp_in_valid & resp_out_ready`) with EOM = 1.
- Simultaneous increment and decrement leave the count unchanged.
- Counter at 2^OW−1: `open` is forced low for new response-expecting packets (backpressure).
- Decrement at 0: count stays 0 and `drain_err` is set.
- `mid_pkt` is set on an accepted request with EOM = 0 and cleared on an accepted request with EOM = 1. Gating never splits a multi-packet request.
- Response channel is always pass-through (`resp_in_ready = resp_out_ready`). Clamping in ISOLATED is done by `umi_isolate`.
- FSM (encoding in package):
  - ACTIVE: `iso_req` → DRAIN.
  - DRAIN: blocks new packets. `outstanding==0 & !mid_pkt` → ISOLATED. Timer reaching DRAIN_TIMEOUT → ISOLATED with `drain_err` set and counter cleared to 0. `iso_req` dropped → ACTIVE.
  - ISOLATED: `isolate`=1. `!iso_req` → WAKE.
  - WAKE: `isolate`=0, traffic blocked. After WAKE_CYCLES → ACTIVE. `iso_req` reasserted → ISOLATED.

## Timing
- Reset values: state ACTIVE, `isolate`=0, `iso_ack`=0, `drain_err`=0, `outstanding`=0, `mid_pkt`=0, timers 0.
- Reset mid-operation returns everything to these values on the next edge.
- Zero-cycle datapath latency.
- `isolate` and `iso_ack` rise on the same edge that enters ISOLATED. With no traffic in flight, `iso_req` high at edge N puts the block in DRAIN at N+1 and ISOLATED at N+2.
- `isolate` falls on the edge entering WAKE. Traffic reopens exactly WAKE_CYCLES edges later.
- Gating changes take effect the cycle after the state change. Valid is never withdrawn mid-handshake, because the gate only closes at packet boundaries while a request is not stalled mid-packet.

## Structure
- `umi_isolate_ctrl_pkg`: state enum (ACTIVE/DRAIN/ISOLATED/WAKE), UMI opcode constants, EOM bit index, `needs_resp()` function.
- One sub-module, `umi_isolate_ctrl_cnt`: saturating up/down outstanding counter with underflow flag.

## Test plan
- Idle drain: no traffic, `iso_req`=1 → `isolate`=1 two edges later, `iso_ack`=1; drop `iso_req` → traffic resumes after 16 cycles.
- 3 REQ_READ accepted, `iso_req`=1 → `req_in_ready`=0, `isolate` stays 0 until 3rd read response (EOM=1) accepted, then rises next edge.
- Multi-packet write (EOM=0,0,1) with `iso_req` raised after packet 1 → packets 2–3 still pass, then gate closes.
- REQ_POSTED ×4 then `iso_req` → `outstanding`=0, isolation in 2 edges.
- Read with no response, DRAIN_TIMEOUT=8 → `isolate`=1 and `drain_err`=1 after 8 DRAIN cycles, `outstanding`=0.
- Stray response at count 0 → `drain_err`=1, count stays 0. Reset mid-DRAIN → all outputs return to reset values.
